register_forward: RTL and testbench

//  Pipeline data-forwarding unit for the EX stage. Compares the two source

---
 rtl/fwd_pkg.sv | 14 +
 rtl/fwd_select.sv | 36 +++
 rtl/register_forward.sv | 57 +++++
 tb/tb_register_forward.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding unit.
package fwd_pkg;

    // Width of a register number: 16 general-purpose registers.
    localparam int REG_ADDR_W_DEF = 4;

    // Operand mux select type and its legal encodings.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;  // take the register-file value
    localparam fwd_sel_t FWD_MEM = 2'b01;  // take the EX/MEM ALU result
    localparam fwd_sel_t FWD_WB  = 2'b10;  // take the MEM/WB write-back value

endpackage : fwd_pkg

// File: rtl/fwd_select.sv
// Single-operand forwarding decision: chooses where one ALU source operand
// comes from, preferring the newest in-flight result.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] op_x,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    output fwd_sel_t              sel
);

    fwd_sel_t sel_d;

    // Priority compare: reset gates everything, MEM (newer) beats WB, and any
    // unresolved or unknown compare falls through to the register-file value.
    always_comb begin
        sel_d = FWD_REG;
        if (!rst) begin
            sel_d = FWD_REG;
        end else if (mem_reg_write && (mem_rd == op_x)) begin
            sel_d = FWD_MEM;
        end else if (wb_reg_write && (wb_rd == op_x)) begin
            sel_d = FWD_WB;
        end else begin
            sel_d = FWD_REG;
        end
    end

    assign sel = sel_d;

endmodule : fwd_select

// File: rtl/register_forward.sv
// EX-stage data-forwarding unit: drives the two ALU operand mux selects so
// each source operand comes from the newest in-flight result.
module register_forward
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] op1,
    input  logic [REG_ADDR_W-1:0] op2,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic [REG_ADDR_W-1:0] wbRd,
    input  logic                  memRegWrite,
    input  logic                  wbRegWrite,
    output logic [1:0]            aluSrc2,
    output logic [1:0]            aluSrc3
);

    // The unit holds no state; the clock is part of the pipeline-side
    // interface only and is deliberately left unconsumed.
    logic unused_clk;
    assign unused_clk = clk;

    fwd_sel_t sel_op1;
    fwd_sel_t sel_op2;

    // Operand A select, driven from source register 1.
    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_op1 (
        .rst           (rst),
        .op_x          (op1),
        .mem_rd        (memRd),
        .wb_rd         (wbRd),
        .mem_reg_write (memRegWrite),
        .wb_reg_write  (wbRegWrite),
        .sel           (sel_op1)
    );

    // Operand B select, driven from source register 2.
    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_op2 (
        .rst           (rst),
        .op_x          (op2),
        .mem_rd        (memRd),
        .wb_rd         (wbRd),
        .mem_reg_write (memRegWrite),
        .wb_reg_write  (wbRegWrite),
        .sel           (sel_op2)
    );

    assign aluSrc2 = sel_op1;
    assign aluSrc3 = sel_op2;

endmodule : register_forward

// File: tb/tb_register_forward.sv
// Self-checking bench for register_forward: directed cases followed by
// randomized traffic compared against a producer-list reference model.
module tb_register_forward;

    logic       clk;
    logic       rst;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] memRd;
    logic [3:0] wbRd;
    logic       memRegWrite;
    logic       wbRegWrite;
    logic [1:0] aluSrc2;
    logic [1:0] aluSrc3;

    int checks = 0;
    int passed = 0;

    register_forward #(
        .REG_ADDR_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op1         (op1),
        .op2         (op2),
        .memRd       (memRd),
        .wbRd        (wbRd),
        .memRegWrite (memRegWrite),
        .wbRegWrite  (wbRegWrite),
        .aluSrc2     (aluSrc2),
        .aluSrc3     (aluSrc3)
    );

    // Free-running clock; the design is combinational but the bench paces on it.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the in-flight producers from newest to oldest and return
    // the mux code of the first one that writes the wanted register.
    function automatic logic [1:0] refSel(input logic [3:0] src,
                                          input logic [3:0] mRd, input logic mWe,
                                          input logic [3:0] wRd, input logic wWe,
                                          input logic rstn);
        logic [3:0] rdList [2];
        logic       weList [2];
        logic [1:0] codeList [2];
        if (!rstn) return 2'b00;
        rdList[0] = mRd;  weList[0] = mWe;  codeList[0] = 2'b01;
        rdList[1] = wRd;  weList[1] = wWe;  codeList[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            if (weList[i] && rdList[i] == src) return codeList[i];
        end
        return 2'b00;
    endfunction

    // Drive a new set of pipeline register numbers shortly after a rising edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] mRd, input logic mWe,
                                 input logic [3:0] wRd, input logic wWe);
        @(posedge clk);
        #2;
        op1 = a;
        op2 = b;
        memRd = mRd;
        memRegWrite = mWe;
        wbRd = wRd;
        wbRegWrite = wWe;
        #1;
    endtask

    // Compare both selects against expected values.
    task automatic checkOutput(input string tag, input logic [1:0] exp2, input logic [1:0] exp3);
        checks++;
        assert (aluSrc2 === exp2) passed++;
        else $error("[TB] FAIL %s aluSrc2: got %b expected %b", tag, aluSrc2, exp2);
        checks++;
        assert (aluSrc3 === exp3) passed++;
        else $error("[TB] FAIL %s aluSrc3: got %b expected %b", tag, aluSrc3, exp3);
    endtask

    initial begin
        logic [3:0] rA, rB, rM, rW;
        logic       eM, eW;
        logic       doRst;

        rst = 1'b0;
        op1 = 4'd1; op2 = 4'd1; memRd = 4'd1; wbRd = 4'd1;
        memRegWrite = 1'b1; wbRegWrite = 1'b1;
        #3;
        checkOutput("reset_hold", 2'b00, 2'b00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_release", 2'b01, 2'b01);

        // Directed cases
        applyStimulus(4'd1, 4'd2, 4'd1, 1'b1, 4'd0, 1'b0);
        checkOutput("mem_fwd_op1", 2'b01, 2'b00);
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b0, 4'd1, 1'b1);
        checkOutput("wb_fwd_op1", 2'b10, 2'b00);
        applyStimulus(4'd1, 4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
        checkOutput("mem_fwd_op2", 2'b00, 2'b01);
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b0, 4'd2, 1'b1);
        checkOutput("wb_fwd_op2", 2'b00, 2'b10);
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b1, 4'd0, 1'b0);
        checkOutput("r0_nomatch_mem", 2'b00, 2'b00);
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b1);
        checkOutput("r0_nomatch_wb", 2'b00, 2'b00);
        applyStimulus(4'd3, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1);
        checkOutput("mem_wins", 2'b01, 2'b01);
        applyStimulus(4'd0, 4'd5, 4'd0, 1'b1, 4'd5, 1'b1);
        checkOutput("r0_forwarded", 2'b01, 2'b10);
        applyStimulus(4'd7, 4'd7, 4'd7, 1'b0, 4'd7, 1'b0);
        checkOutput("we_suppress", 2'b00, 2'b00);
        applyStimulus(4'd9, 4'd9, 4'd9, 1'b0, 4'd9, 1'b1);
        checkOutput("wb_when_mem_off", 2'b10, 2'b10);

        // Asynchronous reset while a match is present, no clock edge in between
        applyStimulus(4'd3, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_assert", 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_release", 2'b01, 2'b01);

        // Unknown source register must never yield 2'b11
        applyStimulus(4'bxxxx, 4'd4, 4'd4, 1'b1, 4'd6, 1'b1);
        checkOutput("x_operand", 2'b00, 2'b01);

        // Randomized traffic over a narrow register range to provoke matches
        for (int n = 0; n < 300; n++) begin
            rA = 4'($urandom_range(0, 3));
            rB = 4'($urandom_range(0, 3));
            rM = 4'($urandom_range(0, 3));
            rW = 4'($urandom_range(0, 3));
            if (n % 5 == 0) begin
                rA = 4'($urandom_range(0, 15));
                rW = 4'($urandom_range(0, 15));
            end
            eM = 1'($urandom_range(0, 1));
            eW = 1'($urandom_range(0, 1));
            doRst = ($urandom_range(0, 15) == 0);
            applyStimulus(rA, rB, rM, eM, rW, eW);
            if (doRst) begin
                rst = 1'b0;
                #1;
            end
            checkOutput($sformatf("rand_%0d", n),
                        refSel(rA, rM, eM, rW, eW, !doRst),
                        refSel(rB, rM, eM, rW, eW, !doRst));
            rst = 1'b1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_register_forward
